sram_axi_arbiter: RTL and testbench

- Parametrised N-port arbiter between SRAM-like CPU memory ports (inst fetch, data load/store, future ports) and the single-channel axi_interface request port (mem_a/mem_access/mem_ready).
- Replaces the fixed 2-port inst_miss select logic.
- Adds:
  - fixed-priority or round-robin arbitration;
  - registered request capture;
  - per-port flush with response drain;
  - kseg0/kseg1 address remap.

---
 rtl/sram_axi_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_axi_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_arbiter.sv
// N-port arbiter from SRAM-like CPU ports onto one downstream request port.
// Registered capture, flush with response drain, kseg0/kseg1 remap.
module sram_axi_arbiter #(
  parameter int NPORT = 2,
  parameter int RR    = 1,
  parameter int REMAP = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    p_req,
  input  logic [NPORT-1:0]    p_wr,
  input  logic [2*NPORT-1:0]  p_size,
  input  logic [4*NPORT-1:0]  p_sel,
  input  logic [32*NPORT-1:0] p_addr,
  input  logic [32*NPORT-1:0] p_wdata,
  input  logic [NPORT-1:0]    p_flush,
  output logic [NPORT-1:0]    p_ready,
  output logic [31:0]         p_rdata,
  output logic [31:0]         mem_a,
  output logic                mem_access,
  output logic                mem_write,
  output logic [1:0]          mem_size,
  output logic [3:0]          mem_sel,
  output logic [31:0]         mem_st_data,
  input  logic                mem_ready,
  input  logic [31:0]         mem_data,
  output logic                busy
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int SW = IW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [NPORT-1:0]  rdy_q, rdy_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              acc_q, acc_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       st_q, st_d;

  logic [NPORT-1:0]   elig;
  logic [2*NPORT-1:0] rot;
  logic [IW-1:0]      base;
  logic [IW-1:0]      win;
  logic               found;
  logic [SW-1:0]      sum;
  logic [IW-1:0]      nxt;
  logic               flush_g;

  function automatic logic [31:0] remap(input logic [31:0] a);
    if (REMAP != 0 && a[31:30] == 2'b10) return {3'b000, a[28:0]};
    return a;
  endfunction

  assign elig    = p_req & ~p_flush;
  assign base    = (RR != 0) ? ptr_q : '0;
  assign rot     = {elig, elig} >> base;
  assign flush_g = p_flush[gnt_q];
  assign nxt     = (gnt_q == IW'(NPORT - 1)) ? '0 : gnt_q + IW'(1);

  // Winner: first eligible port searching upward from base, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, base} + SW'(k);
        if (sum >= SW'(NPORT)) sum = sum - SW'(NPORT);
        win   = sum[IW-1:0];
      end
    end
  end

  // Next-state, capture and completion logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    rdy_d   = '0;
    rdata_d = rdata_q;
    acc_d   = acc_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sel_d   = sel_q;
    a_d     = a_q;
    st_d    = st_q;
    unique case (state_q)
      IDLE: begin
        acc_d = 1'b0;
        if (found) begin
          gnt_d   = win;
          wr_d    = p_wr[win];
          size_d  = p_size[2*win +: 2];
          sel_d   = p_sel[4*win +: 4];
          a_d     = remap(p_addr[32*win +: 32]);
          st_d    = p_wdata[32*win +: 32];
          acc_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          acc_d   = 1'b0;
          state_d = IDLE;
          if (RR != 0) ptr_d = nxt;
          if (!flush_g) begin
            rdy_d[gnt_q] = 1'b1;
            rdata_d      = mem_data;
          end
        end else if (flush_g) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          acc_d   = 1'b0;
          state_d = IDLE;
          if (RR != 0) ptr_d = nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      rdy_q   <= '0;
      rdata_q <= '0;
      acc_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      sel_q   <= '0;
      a_q     <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      st_q    <= st_d;
    end
  end

  assign p_ready     = rdy_q;
  assign p_rdata     = rdata_q;
  assign mem_a       = a_q;
  assign mem_access  = acc_q;
  assign mem_write   = wr_q;
  assign mem_size    = size_q;
  assign mem_sel     = sel_q;
  assign mem_st_data = st_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter: a 2-port round-robin instance
// and a 4-port fixed-priority instance.
module tb_sram_axi_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic [1:0]  a_req = '0, a_wr = '0, a_flush = '0, a_ready;
  logic [3:0]  a_size = '0;
  logic [7:0]  a_sel = '0;
  logic [63:0] a_addr = '0, a_wdata = '0;
  logic [31:0] a_rdata, a_ma, a_mst, a_mdata = '0;
  logic        a_acc, a_mw, a_mrdy = 1'b0, a_busy;
  logic [1:0]  a_ms;
  logic [3:0]  a_msel;

  logic [3:0]   b_req = '0, b_wr = '0, b_flush = '0, b_ready;
  logic [7:0]   b_size = '0;
  logic [15:0]  b_sel = '0;
  logic [127:0] b_addr = '0, b_wdata = '0;
  logic [31:0]  b_rdata, b_ma, b_mst, b_mdata = '0;
  logic         b_acc, b_mw, b_mrdy = 1'b0, b_busy;
  logic [1:0]   b_ms;
  logic [3:0]   b_msel;

  sram_axi_arbiter #(.NPORT(2), .RR(1), .REMAP(1)) u_a (
    .clk(clk), .rst(rst),
    .p_req(a_req), .p_wr(a_wr), .p_size(a_size), .p_sel(a_sel),
    .p_addr(a_addr), .p_wdata(a_wdata), .p_flush(a_flush),
    .p_ready(a_ready), .p_rdata(a_rdata),
    .mem_a(a_ma), .mem_access(a_acc), .mem_write(a_mw),
    .mem_size(a_ms), .mem_sel(a_msel), .mem_st_data(a_mst),
    .mem_ready(a_mrdy), .mem_data(a_mdata), .busy(a_busy)
  );

  sram_axi_arbiter #(.NPORT(4), .RR(0), .REMAP(1)) u_b (
    .clk(clk), .rst(rst),
    .p_req(b_req), .p_wr(b_wr), .p_size(b_size), .p_sel(b_sel),
    .p_addr(b_addr), .p_wdata(b_wdata), .p_flush(b_flush),
    .p_ready(b_ready), .p_rdata(b_rdata),
    .mem_a(b_ma), .mem_access(b_acc), .mem_write(b_mw),
    .mem_size(b_ms), .mem_sel(b_msel), .mem_st_data(b_mst),
    .mem_ready(b_mrdy), .mem_data(b_mdata), .busy(b_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({a_ready, a_rdata, a_ma, a_acc, a_mw, a_ms, a_msel, a_mst, a_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got acc=%0b busy=%0b ma=%h rdy=%b want all zero",
               a_acc, a_busy, a_ma, a_ready);
    end
    n_chk++;
    if ({b_ready, b_rdata, b_ma, b_acc, b_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got acc=%0b busy=%0b ma=%h want all zero", b_acc, b_busy, b_ma);
    end
    a_mrdy = 1'b1;
    a_mdata = 32'h1234_5678;
    tick();
    a_mrdy = 1'b0;
    tick();
    n_chk++;
    if (a_ready !== 2'b00 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_stray_ready: got rdy=%b busy=%0b want 00/0", a_ready, a_busy);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    a_addr[32 +: 32] = 32'h8000_1000;
    a_wr = '0;
    a_req = 2'b10;
    tick();
    n_chk++;
    if (a_acc !== 1'b1 || a_ma !== 32'h0000_1000 || a_mw !== 1'b0) begin
      n_fail++;
      $display("FAIL read_issue: got acc=%0b ma=%h mw=%0b want 1/00001000/0", a_acc, a_ma, a_mw);
    end
    a_mrdy = 1'b1;
    a_mdata = 32'hDEAD_BEEF;
    tick();
    a_mrdy = 1'b0;
    a_req = 2'b00;
    n_chk++;
    if (a_ready !== 2'b10 || a_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL read_resp: got rdy=%b rdata=%h want 10/deadbeef", a_ready, a_rdata);
    end
    n_chk++;
    if (a_acc !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL read_done: got acc=%0b busy=%0b want 0/0", a_acc, a_busy);
    end
    tick();
    n_chk++;
    if (a_ready !== 2'b00 || a_acc !== 1'b0) begin
      n_fail++;
      $display("FAIL read_pulse: got rdy=%b acc=%0b want 00/0", a_ready, a_acc);
    end
  endtask

  task automatic test_rr_contention();
    logic [31:0] exp_a;
    logic [1:0]  exp_r;
    do_reset();
    a_addr = {32'h0000_0200, 32'h0000_0100};
    a_req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_a = (g % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      exp_r = (g % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      n_chk++;
      if (a_acc !== 1'b1 || a_ma !== exp_a) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got acc=%0b ma=%h want 1/%h", g, a_acc, a_ma, exp_a);
      end
      a_mrdy = 1'b1;
      a_mdata = 32'hC0DE_0000 + 32'(g);
      tick();
      a_mrdy = 1'b0;
      n_chk++;
      if (a_ready !== exp_r || a_rdata !== 32'hC0DE_0000 + 32'(g)) begin
        n_fail++;
        $display("FAIL rr_resp%0d: got rdy=%b rdata=%h want %b/%h",
                 g, a_ready, a_rdata, exp_r, 32'hC0DE_0000 + 32'(g));
      end
    end
    a_req = 2'b00;
    tick();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int i = 0; i < 4; i++) b_addr[32*i +: 32] = 32'h0000_1000 * 32'(i + 1);
    b_req = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++;
      if (b_acc !== 1'b1 || b_ma !== 32'h0000_1000) begin
        n_fail++;
        $display("FAIL fp_grant%0d: got acc=%0b ma=%h want 1/00001000", k, b_acc, b_ma);
      end
      b_mrdy = 1'b1;
      b_mdata = 32'h1111_0000 + 32'(k);
      tick();
      b_mrdy = 1'b0;
      n_chk++;
      if (b_ready !== 4'b0001 || b_rdata !== 32'h1111_0000 + 32'(k)) begin
        n_fail++;
        $display("FAIL fp_resp%0d: got rdy=%b rdata=%h want 0001", k, b_ready, b_rdata);
      end
    end
    b_req = 4'b0010;
    tick();
    n_chk++;
    if (b_acc !== 1'b1 || b_ma !== 32'h0000_2000) begin
      n_fail++;
      $display("FAIL fp_port1: got acc=%0b ma=%h want 1/00002000", b_acc, b_ma);
    end
    b_mrdy = 1'b1;
    b_mdata = 32'h2222_2222;
    tick();
    b_mrdy = 1'b0;
    b_req = 4'b0000;
    n_chk++;
    if (b_ready !== 4'b0010 || b_rdata !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL fp_port1_resp: got rdy=%b rdata=%h want 0010/22222222", b_ready, b_rdata);
    end
    tick();
  endtask

  task automatic test_write_remap();
    do_reset();
    a_wr = 2'b10;
    a_size = 4'b0000;
    a_sel = 8'b0100_0000;
    a_addr = {32'hBFAF_F008, 32'h0};
    a_wdata = {32'h00AB_0000, 32'h0};
    a_req = 2'b10;
    tick();
    n_chk++;
    if (a_mw !== 1'b1 || a_msel !== 4'b0100 || a_ma !== 32'h1FAF_F008 ||
        a_mst !== 32'h00AB_0000 || a_ms !== 2'd0) begin
      n_fail++;
      $display("FAIL write_issue: got mw=%0b sel=%b ma=%h st=%h sz=%0d want 1/0100/1faff008/00ab0000/0",
               a_mw, a_msel, a_ma, a_mst, a_ms);
    end
    a_addr[32 +: 32] = 32'h0000_0044;
    a_wdata[32 +: 32] = 32'hFFFF_FFFF;
    a_wr = 2'b00;
    a_req = 2'b11;
    a_addr[31:0] = 32'hC000_0010;
    tick();
    n_chk++;
    if (a_ma !== 32'h1FAF_F008 || a_mst !== 32'h00AB_0000 || a_mw !== 1'b1) begin
      n_fail++;
      $display("FAIL write_hold: got ma=%h st=%h mw=%0b want 1faff008/00ab0000/1", a_ma, a_mst, a_mw);
    end
    a_mrdy = 1'b1;
    tick();
    a_mrdy = 1'b0;
    a_req = 2'b01;
    n_chk++;
    if (a_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL write_resp: got rdy=%b want 10", a_ready);
    end
    tick();
    n_chk++;
    if (a_ma !== 32'hC000_0010 || a_mw !== 1'b0) begin
      n_fail++;
      $display("FAIL no_remap_kseg2: got ma=%h mw=%0b want c0000010/0", a_ma, a_mw);
    end
    a_mrdy = 1'b1;
    tick();
    a_mrdy = 1'b0;
    a_req = 2'b00;
    tick();
  endtask

  task automatic test_flush_drain();
    do_reset();
    a_wr = '0;
    a_addr = {32'h0000_0200, 32'h0000_0100};
    a_req = 2'b11;
    tick();
    a_flush = 2'b01;
    tick();
    a_flush = 2'b00;
    a_req = 2'b10;
    n_chk++;
    if (a_acc !== 1'b1 || a_busy !== 1'b1 || a_ready !== 2'b00 || a_ma !== 32'h0000_0100) begin
      n_fail++;
      $display("FAIL drain_enter: got acc=%0b busy=%0b rdy=%b ma=%h want 1/1/00/00000100",
               a_acc, a_busy, a_ready, a_ma);
    end
    tick();
    n_chk++;
    if (a_acc !== 1'b1 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_hold: got acc=%0b busy=%0b want 1/1", a_acc, a_busy);
    end
    a_mrdy = 1'b1;
    a_mdata = 32'hBAD0_BAD0;
    tick();
    a_mrdy = 1'b0;
    n_chk++;
    if (a_ready !== 2'b00 || a_acc !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_exit: got rdy=%b acc=%0b busy=%0b want 00/0/0", a_ready, a_acc, a_busy);
    end
    tick();
    n_chk++;
    if (a_acc !== 1'b1 || a_ma !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL drain_next: got acc=%0b ma=%h want 1/00000200", a_acc, a_ma);
    end
    a_mrdy = 1'b1;
    a_mdata = 32'h600D_600D;
    tick();
    a_mrdy = 1'b0;
    a_req = 2'b00;
    n_chk++;
    if (a_ready !== 2'b10 || a_rdata !== 32'h600D_600D) begin
      n_fail++;
      $display("FAIL drain_next_resp: got rdy=%b rdata=%h want 10/600d600d", a_ready, a_rdata);
    end
    tick();
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    a_addr = {32'h0000_0200, 32'h0000_0100};
    a_req = 2'b11;
    tick();
    a_flush = 2'b10;
    tick();
    a_flush = 2'b00;
    n_chk++;
    if (a_acc !== 1'b1 || a_ma !== 32'h0000_0100 || a_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL other_flush: got acc=%0b ma=%h busy=%0b want 1/00000100/1", a_acc, a_ma, a_busy);
    end
    a_mrdy = 1'b1;
    a_mdata = 32'hAAAA_5555;
    tick();
    a_mrdy = 1'b0;
    n_chk++;
    if (a_ready !== 2'b01 || a_rdata !== 32'hAAAA_5555) begin
      n_fail++;
      $display("FAIL other_flush_resp: got rdy=%b rdata=%h want 01/aaaa5555", a_ready, a_rdata);
    end
    tick();
    n_chk++;
    if (a_acc !== 1'b1 || a_ma !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL same_grant: got acc=%0b ma=%h want 1/00000200", a_acc, a_ma);
    end
    a_mrdy = 1'b1;
    a_flush = 2'b10;
    tick();
    a_mrdy = 1'b0;
    a_flush = 2'b00;
    a_req = 2'b00;
    n_chk++;
    if (a_ready !== 2'b00 || a_acc !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_flush: got rdy=%b acc=%0b busy=%0b want 00/0/0", a_ready, a_acc, a_busy);
    end
    tick();
    n_chk++;
    if (a_ready !== 2'b00 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_after: got rdy=%b busy=%0b want 00/0", a_ready, a_busy);
    end
  endtask

  task automatic test_reset_busy();
    b_addr[96 +: 32] = 32'h0000_4000;
    b_wdata[96 +: 32] = 32'h5A5A_5A5A;
    b_wr = 4'b1000;
    b_size = 8'b1000_0000;
    b_sel = 16'hF000;
    b_req = 4'b1000;
    tick();
    n_chk++;
    if (b_acc !== 1'b1 || b_ma !== 32'h0000_4000 || b_mw !== 1'b1 || b_msel !== 4'hF) begin
      n_fail++;
      $display("FAIL rst_busy_issue: got acc=%0b ma=%h mw=%0b sel=%h want 1/00004000/1/f",
               b_acc, b_ma, b_mw, b_msel);
    end
    rst = 1'b1;
    b_req = 4'b0000;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({b_ready, b_rdata, b_ma, b_acc, b_mw, b_ms, b_msel, b_mst, b_busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_busy_clear: got rdy=%b rdata=%h ma=%h acc=%0b mw=%0b sz=%0d sel=%h st=%h busy=%0b want 0",
               b_ready, b_rdata, b_ma, b_acc, b_mw, b_ms, b_msel, b_mst, b_busy);
    end
    b_mrdy = 1'b1;
    b_mdata = 32'hFEED_FACE;
    tick();
    b_mrdy = 1'b0;
    tick();
    n_chk++;
    if (b_ready !== 4'b0000 || b_busy !== 1'b0 || b_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_late_ready: got rdy=%b busy=%0b rdata=%h want 0000/0/0", b_ready, b_busy, b_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_rr_contention();
    test_fixed_priority();
    test_write_remap();
    test_flush_drain();
    test_flush_same_cycle();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
